// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the pins, deserializes 11-bit frames
// and shifts each valid scan byte into a two-byte history word.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key,
    output logic        key_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s0, clk_s1, dat_s0, dat_s1;
    logic          filt, fall;
    logic [FW-1:0] fcnt;
    state_t        state;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s0 <= 1'b1;
            clk_s1 <= 1'b1;
            dat_s0 <= 1'b1;
            dat_s1 <= 1'b1;
        end else begin
            clk_s0 <= ps2_clk;
            clk_s1 <= clk_s0;
            dat_s0 <= ps2_data;
            dat_s1 <= dat_s0;
        end
    end

    // fcnt counts consecutive samples that disagree with the filtered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b1;
            fcnt <= '0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s1 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FLAST) begin
                filt <= clk_s1;
                fcnt <= '0;
                fall <= ~clk_s1;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcnt      <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tcnt      <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (state)
                    IDLE: if (!dat_s1) begin
                        state <= DATA;
                        bcnt  <= '0;
                    end
                    DATA: begin
                        shreg[bcnt] <= dat_s1;
                        bcnt        <= bcnt + 1'b1;
                        if (bcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat_s1;
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (dat_s1 && (^{shreg, par})) begin
                            key       <= {key[7:0], shreg};
                            key_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TLIM) begin
                // stalled mid-frame: drop the partial byte, key untouched
                state     <= IDLE;
                tcnt      <= '0;
                frame_err <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: table of frames plus timeout, glitch and reset sequences.
module tb_ps2_scancode_rx;
    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key;
    logic        key_valid, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int nv = 0;
    int ne = 0;
    bit busy_seen = 1'b0;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key), .key_valid(key_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) nv++;
        if (frame_err) ne++;
        if (busy) busy_seen = 1'b1;
        if (key_valid || frame_err) chk("valid_err_exclusive", {31'd0, key_valid & frame_err}, 32'd0);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(bad ? (^d) : ~(^d));
        send_bit(1'b1);
        wait_cyc(20);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);
    endtask

    typedef struct {
        logic        rst_first;
        logic [7:0]  data;
        logic        bad;
        logic [15:0] exp_key;
        int          exp_valid;
        int          exp_err;
    } vec_t;

    vec_t vec[6];

    initial begin
        vec[0] = '{1'b1, 8'h1C, 1'b0, 16'h001C, 1, 0};
        vec[1] = '{1'b0, 8'hF0, 1'b0, 16'h1CF0, 1, 0};
        vec[2] = '{1'b0, 8'h1C, 1'b0, 16'hF01C, 1, 0};
        vec[3] = '{1'b1, 8'h1C, 1'b0, 16'h001C, 1, 0};
        vec[4] = '{1'b0, 8'h23, 1'b1, 16'h001C, 0, 1};
        vec[5] = '{1'b0, 8'h23, 1'b0, 16'h1C23, 1, 0};

        wait_cyc(3);
        @(negedge clk);
        chk("reset_key", {16'd0, key}, 32'h0);
        chk("reset_valid", {31'd0, key_valid}, 32'd0);
        chk("reset_err", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(4);

        for (int i = 0; i < 6; i++) begin
            if (vec[i].rst_first) do_reset();
            nv = 0;
            ne = 0;
            send_frame(vec[i].data, vec[i].bad);
            @(negedge clk);
            chk($sformatf("row%0d_key", i), {16'd0, key}, {16'd0, vec[i].exp_key});
            chk($sformatf("row%0d_valid_cnt", i), nv, vec[i].exp_valid);
            chk($sformatf("row%0d_err_cnt", i), ne, vec[i].exp_err);
            chk($sformatf("row%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        // timeout: start + 4 data bits, then the clock stalls high
        nv = 0;
        ne = 0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        @(negedge clk);
        chk("to_busy_mid", {31'd0, busy}, 32'd1);
        wait_cyc(TO + 10);
        @(negedge clk);
        chk("to_err_cnt", ne, 1);
        chk("to_valid_cnt", nv, 0);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_key", {16'd0, key}, 32'h1C23);
        send_frame(8'h1D, 1'b0);
        @(negedge clk);
        chk("to_recover_key", {16'd0, key}, 32'h231D);

        // glitch: 3-cycle low on ps2_clk with data low in IDLE
        busy_seen = 1'b0;
        nv = 0;
        ne = 0;
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(30);
        ps2_data = 1'b1;
        wait_cyc(5);
        chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd0);
        chk("glitch_err_cnt", ne, 0);
        send_frame(8'h1B, 1'b0);
        @(negedge clk);
        chk("glitch_recover_key", {16'd0, key}, 32'h1D1B);
        chk("glitch_valid_cnt", nv, 1);

        // reset in the middle of a frame
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge clk);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_key", {16'd0, key}, 32'h0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);
        nv = 0;
        send_frame(8'h1C, 1'b0);
        @(negedge clk);
        chk("mid_recover_key", {16'd0, key}, 32'h001C);
        chk("mid_valid_cnt", nv, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
